// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared state encoding and default parameters for the PLL reset sequencer
package pll_reset_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FILTER = 3'd1,
        S_HOLD   = 3'd2,
        S_RUN    = 3'd3,
        S_LOST   = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_FILTER_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES        = 64;
    localparam int DEF_LOSS_CNT_WIDTH     = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit, clears to 0 on reset
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the asynchronous input one stage deeper each edge
    always_comb sync_d = {sync_q[STAGES-2:0], d};

    // synchronizer flops, cleared asynchronously so lock never looks valid during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the processor in reset until PLL lock is stable, re-asserting on lock loss
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER_CYCLES = DEF_LOCK_FILTER_CYCLES,
    parameter int HOLD_CYCLES        = DEF_HOLD_CYCLES,
    parameter int LOSS_CNT_WIDTH     = DEF_LOSS_CNT_WIDTH
) (
    input  logic                      clk_proc,
    input  logic                      rst,
    input  logic                      pll_locked,
    output logic                      rst_proc,
    output logic                      proc_ready,
    output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count,
    output logic [2:0]                state_dbg
);

    localparam int FW = LOCK_FILTER_CYCLES > 1 ? $clog2(LOCK_FILTER_CYCLES) : 1;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [FW-1:0] FILTER_LAST = FW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

    logic                      lock_s;
    state_t                    state_q, state_d;
    logic [FW-1:0]             filter_cnt_q, filter_cnt_d;
    logic [HW-1:0]             hold_cnt_q, hold_cnt_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_cnt_q, loss_cnt_d;
    logic                      rst_proc_q, rst_proc_d;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk_proc),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // next-state, counters and the registered reset output, all derived from the FSM
    always_comb begin
        state_d      = state_q;
        filter_cnt_d = filter_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        case (state_q)
            S_RESET: begin
                state_d      = S_FILTER;
                filter_cnt_d = '0;
            end
            S_FILTER: begin
                if (!lock_s) begin
                    filter_cnt_d = '0;
                end else if (filter_cnt_q == FILTER_LAST) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    filter_cnt_d = filter_cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!lock_s)                    state_d    = S_LOST;
                else if (hold_cnt_q == HOLD_LAST) state_d  = S_RUN;
                else                            hold_cnt_d = hold_cnt_q + 1'b1;
            end
            S_RUN: begin
                if (!lock_s) state_d = S_LOST;
            end
            S_LOST: begin
                state_d      = S_FILTER;
                filter_cnt_d = '0;
            end
            default: state_d = S_RESET;
        endcase
        if (state_d == S_LOST && state_q != S_LOST && loss_cnt_q != '1)
            loss_cnt_d = loss_cnt_q + 1'b1;
        rst_proc_d = (state_d != S_RUN);
    end

    // state and counter registers; reset forces the processor into reset immediately
    always_ff @(posedge clk_proc or posedge rst) begin
        if (rst) begin
            state_q      <= S_RESET;
            filter_cnt_q <= '0;
            hold_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            rst_proc_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            filter_cnt_q <= filter_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            rst_proc_q   <= rst_proc_d;
        end
    end

    assign rst_proc        = rst_proc_q;
    assign proc_ready      = !rst_proc_q;
    assign lock_loss_count = loss_cnt_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of lock filtering, hold, loss handling, saturation and async reset
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst, pll_locked;
    logic       rst_proc, proc_ready;
    logic [7:0] lock_loss_count;
    logic [2:0] state_dbg;

    logic       rst2, locked2;
    logic       rst_proc2, ready2;
    logic [1:0] cnt2;
    logic [2:0] state2;

    int checks = 0;
    int failures = 0;

    pll_reset_sequencer dut (
        .clk_proc        (clk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .rst_proc        (rst_proc),
        .proc_ready      (proc_ready),
        .lock_loss_count (lock_loss_count),
        .state_dbg       (state_dbg)
    );

    // small configuration: release latency 2+2+4 = 8 edges, 2-bit loss counter
    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_FILTER_CYCLES (2),
        .HOLD_CYCLES        (4),
        .LOSS_CNT_WIDTH     (2)
    ) dut2 (
        .clk_proc        (clk),
        .rst             (rst2),
        .pll_locked      (locked2),
        .rst_proc        (rst_proc2),
        .proc_ready      (ready2),
        .lock_loss_count (cnt2),
        .state_dbg       (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0;
        rst2 = 1'b1; locked2 = 1'b0;

        // power-up: reset held, lock low
        tick(5);
        chk("por_rst_proc", rst_proc, 1);
        chk("por_ready", proc_ready, 0);
        chk("por_state", state_dbg, 0);
        chk("por_count", lock_loss_count, 0);
        rst = 1'b0;
        tick(20);
        chk("idle_state", state_dbg, 1);
        chk("idle_rst_proc", rst_proc, 1);
        chk("idle_ready", proc_ready, 0);
        chk("idle_count", lock_loss_count, 0);

        // clean lock: release exactly at edge 82
        pll_locked = 1'b1;
        tick(81);
        chk("clean_e81_rst_proc", rst_proc, 1);
        tick();
        chk("clean_e82_rst_proc", rst_proc, 0);
        chk("clean_e82_ready", proc_ready, 1);
        chk("clean_e82_state", state_dbg, 3);
        chk("clean_e82_count", lock_loss_count, 0);

        // loss in run: one-cycle drop
        tick(5);
        pll_locked = 1'b0;
        tick();
        chk("run_loss_e1_rst_proc", rst_proc, 0);
        pll_locked = 1'b1;
        tick(2);
        chk("run_loss_e3_state", state_dbg, 4);
        chk("run_loss_e3_rst_proc", rst_proc, 1);
        chk("run_loss_e3_count", lock_loss_count, 1);
        tick();
        chk("run_loss_e4_state", state_dbg, 1);
        // S_LOST swallows the edge that would start filtering, so release lands on edge 84 after the drop
        tick(79);
        chk("reseq_e83_rst_proc", rst_proc, 1);
        tick();
        chk("reseq_e84_rst_proc", rst_proc, 0);
        chk("reseq_e84_state", state_dbg, 3);

        // back to filter, then lose lock 30 cycles into hold
        pll_locked = 1'b0;
        tick(3);
        chk("drop_state", state_dbg, 4);
        chk("drop_count", lock_loss_count, 2);
        tick(5);
        chk("drop_filter_state", state_dbg, 1);
        pll_locked = 1'b1;
        tick(18);
        chk("hold_entry_state", state_dbg, 2);
        tick(30);
        chk("hold30_state", state_dbg, 2);
        chk("hold30_rst_proc", rst_proc, 1);
        pll_locked = 1'b0;
        tick(3);
        chk("hold_loss_state", state_dbg, 4);
        chk("hold_loss_rst_proc", rst_proc, 1);
        chk("hold_loss_count", lock_loss_count, 3);
        tick();
        chk("hold_loss_next_state", state_dbg, 1);
        chk("hold_loss_next_rst_proc", rst_proc, 1);

        // relock into run, then async reset between edges
        tick(4);
        pll_locked = 1'b1;
        tick(82);
        chk("relock_state", state_dbg, 3);
        chk("relock_ready", proc_ready, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_proc", rst_proc, 1);
        chk("async_ready", proc_ready, 0);
        chk("async_count", lock_loss_count, 0);
        chk("async_state", state_dbg, 0);
        pll_locked = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(3);
        chk("post_rst_state", state_dbg, 1);

        // filter glitch: 10 high, 3 low, then high; release 82 edges after the second rise
        pll_locked = 1'b1;
        tick(10);
        pll_locked = 1'b0;
        tick(3);
        chk("glitch_state", state_dbg, 1);
        pll_locked = 1'b1;
        tick(81);
        chk("glitch_e81_rst_proc", rst_proc, 1);
        tick();
        chk("glitch_e82_rst_proc", rst_proc, 0);
        chk("glitch_e82_count", lock_loss_count, 0);

        // saturation on the 2-bit counter: five losses hold at 3
        rst2 = 1'b0;
        tick();
        chk("sat_start_state", state2, 1);
        for (int i = 0; i < 5; i++) begin
            locked2 = 1'b1;
            tick(7);
            chk("sat_e7_rst_proc", rst_proc2, 1);
            tick();
            chk("sat_e8_rst_proc", rst_proc2, 0);
            locked2 = 1'b0;
            tick(3);
            chk("sat_loss_state", state2, 4);
            chk("sat_count", cnt2, (i + 1 > 3) ? 3 : i + 1);
            tick();
        end
        locked2 = 1'b1;
        tick(8);
        chk("sat_run_ready", ready2, 1);
        chk("sat_run_count", cnt2, 3);
        #3;
        rst2 = 1'b1;
        #1;
        chk("sat_async_rst_proc", rst_proc2, 1);
        chk("sat_async_count", cnt2, 0);
        chk("sat_async_ready", ready2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
